// File: rtl/uart_arb_pkg.sv
// Shared constants and state type for the UART transmit line arbiter.
package uart_arb_pkg;

    localparam logic [7:0] ASCII_LF = 8'h0A;

    localparam int CLOCK_FREQ            = 12_000_000;
    localparam int GAP_TIMEOUT_DEFAULT   = CLOCK_FREQ / 10;
    localparam int START_TIMEOUT_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ACCEPT     = 3'd1,
        ISSUE      = 3'd2,
        WAIT_START = 3'd3,
        WAIT_DONE  = 3'd4
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or cyclically after the pointer.
module rr_picker #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] pointer,
    output logic [$clog2(NUM_REQ)-1:0] grant,
    output logic                       any_req
);

    localparam int IDX_W = $clog2(NUM_REQ);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(pointer) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                grant = IDX_W'(idx);
                found = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/uart_tx_line_arbiter.sv
// Shares one uart_tx among several byte-stream requesters, granting ownership per line
// (released on LF or after an idle gap timeout) so lines never interleave.
module uart_tx_line_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ       = 3,
    parameter int GAP_TIMEOUT   = GAP_TIMEOUT_DEFAULT,
    parameter int START_TIMEOUT = START_TIMEOUT_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [8*NUM_REQ-1:0]         req_data,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [7:0]                   tx_data,
    output logic                         tx_data_valid,
    input  logic                         tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         line_active,
    output logic                         abort_pulse,
    output logic [7:0]                   timeout_count
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int GAP_W   = $clog2(GAP_TIMEOUT + 1);
    localparam int START_W = $clog2(START_TIMEOUT + 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_TIMEOUT - 1);
    localparam logic [START_W-1:0] START_LAST = START_W'(START_TIMEOUT - 1);

    arb_state_t         state;
    logic [IDX_W-1:0]   pointer;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   next_pointer;
    logic               any_req;
    logic               is_lf;
    logic               byte_done;
    logic [GAP_W-1:0]   gap_count;
    logic [START_W-1:0] start_count;
    logic [7:0]         owner_byte;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req     (req_valid),
        .pointer (pointer),
        .grant   (pick),
        .any_req (any_req)
    );

    assign owner_byte   = req_data[8*grant_id +: 8];
    assign next_pointer = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + IDX_W'(1);

    // A missing busy edge (uart_tx dropped the pulse) is treated as a finished byte.
    assign byte_done = !tx_busy &&
                       ((state == WAIT_DONE) || (state == WAIT_START && start_count == START_LAST));

    always_comb begin
        req_ready = '0;
        if (state == ACCEPT) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            tx_data       <= '0;
            tx_data_valid <= 1'b0;
            grant_id      <= '0;
            line_active   <= 1'b0;
            abort_pulse   <= 1'b0;
            timeout_count <= '0;
            pointer       <= '0;
            gap_count     <= '0;
            start_count   <= '0;
            is_lf         <= 1'b0;
        end else begin
            tx_data_valid <= 1'b0;
            abort_pulse   <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id    <= pick;
                        line_active <= 1'b1;
                        gap_count   <= '0;
                        state       <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (req_valid[grant_id]) begin
                        tx_data       <= owner_byte;
                        is_lf         <= (owner_byte == ASCII_LF);
                        gap_count     <= '0;
                        tx_data_valid <= 1'b1;
                        state         <= ISSUE;
                    end else if (gap_count == GAP_LAST) begin
                        line_active <= 1'b0;
                        abort_pulse <= 1'b1;
                        if (timeout_count != 8'hFF) begin
                            timeout_count <= timeout_count + 8'd1;
                        end
                        pointer   <= next_pointer;
                        gap_count <= '0;
                        state     <= IDLE;
                    end else begin
                        gap_count <= gap_count + GAP_W'(1);
                    end
                end
                ISSUE: begin
                    start_count <= '0;
                    state       <= WAIT_START;
                end
                WAIT_START, WAIT_DONE: begin
                    if (byte_done) begin
                        if (is_lf) begin
                            line_active <= 1'b0;
                            pointer     <= next_pointer;
                            state       <= IDLE;
                        end else begin
                            state <= ACCEPT;
                        end
                    end else if (state == WAIT_START) begin
                        if (tx_busy) begin
                            state <= WAIT_DONE;
                        end else begin
                            start_count <= start_count + START_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
